// File: rtl/alu_pkg.sv
// Shared types for the execute-ALU arbiter: operation/response payloads, opcodes, FSM states.
package alu_pkg;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  instr_type;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        branch_taken;
    logic [4:0]  rd;
    logic        tag;
  } alu_rsp_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-pin bundle between the issuers, the arbiter and the ALU.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  alu_req_t   req0_data;
  alu_req_t   req1_data;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  alu_rsp_t   rsp_data;
  alu_req_t   alu_req;
  logic [31:0] alu_result;
  logic        alu_branch_taken;

  modport master (
    output req_valid, req0_data, req1_data, rsp_ready, alu_result, alu_branch_taken,
    input  req_ready, rsp_valid, rsp_data, alu_req
  );

  modport slave (
    input  req_valid, req0_data, req1_data, rsp_ready, alu_result, alu_branch_taken,
    output req_ready, rsp_valid, rsp_data, alu_req
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; ties go to the port that did not win last.
// Combinational grant, last_grant updates only when update is high.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx,
  output logic       any
);

  logic last_grant;

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant_idx;
    end
  end

  always_comb begin
    any       = |req;
    grant_idx = (req == 2'b11) ? ~last_grant : req[1];
    grant     = 2'b00;
    if (any) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready issuers; response at accept+1+EXEC_CYCLES.
// One op in flight; no accept while a response waits on its owner's rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_arbiter: EXEC_CYCLES must be within 1..15");
  end

  state_t     state, state_n;
  alu_req_t   op_reg;
  alu_rsp_t   rsp_q;
  logic       owner;
  logic [3:0] exec_cnt;
  logic [1:0] grant;
  logic       grant_idx, grant_any;
  logic       accept, capture, complete;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    accept        = 1'b0;
    capture       = 1'b0;
    complete      = 1'b0;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    bus.alu_req   = '0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = grant;
        if (grant_any) begin
          accept  = 1'b1;
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.alu_req = op_reg;
        if (exec_cnt == 4'd0) begin
          capture = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = owner ? 2'b10 : 2'b01;
        if (bus.rsp_ready[owner]) begin
          complete = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request is copied on accept so the issuer may change its data immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= '0;
      owner    <= 1'b0;
      exec_cnt <= 4'd0;
      rsp_q    <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        op_reg   <= grant_idx ? bus.req1_data : bus.req0_data;
        owner    <= grant_idx;
        exec_cnt <= 4'(EXEC_CYCLES - 1);
      end else if (state == ST_EXEC && exec_cnt != 4'd0) begin
        exec_cnt <= exec_cnt - 4'd1;
      end
      if (capture) begin
        rsp_q.result       <= bus.alu_result;
        rsp_q.branch_taken <= bus.alu_branch_taken;
        rsp_q.rd           <= op_reg.rd;
        rsp_q.tag          <= owner;
      end
      if (complete) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

  assign bus.rsp_data = rsp_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus contention, backpressure, reset and wrap sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if b1 ();
  alu_arbiter_if b3 ();
  alu_arbiter_if bw ();

  logic        busy1, busy3, busyw;
  logic [31:0] cnt1, cnt3;
  logic [3:0]  cntw;

  alu_arbiter #(.EXEC_CYCLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1), .op_count(cnt1));
  alu_arbiter #(.EXEC_CYCLES(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3), .busy(busy3), .op_count(cnt3));
  alu_arbiter #(.EXEC_CYCLES(1), .CNT_W(4)) u_dutw (
    .clk(clk), .rst(rst), .bus(bw), .busy(busyw), .op_count(cntw));

  // Reference ALU: {branch_taken, result}
  function automatic logic [32:0] alu_model(input alu_req_t r);
    logic [32:0] o;
    o = '0;
    case (r.opcode)
      OP_R:     o[31:0] = (r.funct7 == 7'b0100000) ? r.rs1_data - r.rs2_data : r.rs1_data + r.rs2_data;
      OP_I:     o[31:0] = r.rs1_data + r.imm;
      OP_B:     o[32]   = (r.rs1_data == r.rs2_data);
      OP_LUI:   o[31:0] = r.imm;
      OP_AUIPC: o[31:0] = r.pc + r.imm;
      default:  o = '0;
    endcase
    return o;
  endfunction

  assign {b1.alu_branch_taken, b1.alu_result} = alu_model(b1.alu_req);
  assign {b3.alu_branch_taken, b3.alu_result} = alu_model(b3.alu_req);
  assign {bw.alu_branch_taken, bw.alu_result} = alu_model(bw.alu_req);

  function automatic alu_req_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [31:0] pc);
    alu_req_t r;
    r          = '0;
    r.opcode   = opc;
    r.funct3   = f3;
    r.funct7   = f7;
    r.rd       = rd;
    r.rs1_addr = 5'd1;
    r.rs2_addr = 5'd2;
    r.rs1_data = a;
    r.rs2_data = b;
    r.imm      = imm;
    r.pc       = pc;
    return r;
  endfunction

  typedef struct {
    alu_req_t    op;
    logic        port;
    logic [31:0] exp_res;
    logic        exp_br;
  } vec_t;

  vec_t vecs[8];
  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] oh;
    oh = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    if (v.port) b1.req1_data = v.op; else b1.req0_data = v.op;
    b1.req_valid = oh;
    #1;
    check($sformatf("v%0d_req_ready", idx), b1.req_ready, oh);
    @(negedge clk);
    b1.req_valid = 2'b00;
    b1.req0_data = '0;
    b1.req1_data = '0;
    #1;
    check($sformatf("v%0d_exec_no_rsp", idx), b1.rsp_valid, 2'b00);
    check($sformatf("v%0d_alu_req_held", idx), (b1.alu_req === v.op), 1'b1);
    @(negedge clk);
    check($sformatf("v%0d_rsp_valid", idx), b1.rsp_valid, oh);
    check($sformatf("v%0d_result", idx), b1.rsp_data.result, v.exp_res);
    check($sformatf("v%0d_branch", idx), b1.rsp_data.branch_taken, v.exp_br);
    check($sformatf("v%0d_rd", idx), b1.rsp_data.rd, v.op.rd);
    check($sformatf("v%0d_tag", idx), b1.rsp_data.tag, v.port);
    b1.rsp_ready = oh;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    exp_cnt++;
    check($sformatf("v%0d_done_rsp_valid", idx), b1.rsp_valid, 2'b00);
    check($sformatf("v%0d_op_count", idx), cnt1, exp_cnt);
  endtask

  initial begin
    int n;
    alu_req_t op3;
    vecs[0] = '{mk(OP_R,     3'b000, 7'b0000000, 5'd5,  32'd10, 32'd20, 32'd0, 32'd0), 1'b0, 32'd30, 1'b0};
    vecs[1] = '{mk(OP_R,     3'b000, 7'b0100000, 5'd6,  32'd10, 32'd20, 32'd0, 32'd0), 1'b1, 32'hFFFF_FFF6, 1'b0};
    vecs[2] = '{mk(OP_I,     3'b000, 7'b0000000, 5'd7,  32'd10, 32'd0, 32'd15, 32'd0), 1'b0, 32'd25, 1'b0};
    vecs[3] = '{mk(OP_B,     3'b000, 7'b0000000, 5'd0,  32'd30, 32'd30, 32'd0, 32'd0), 1'b1, 32'd0, 1'b1};
    vecs[4] = '{mk(OP_B,     3'b000, 7'b0000000, 5'd0,  32'd1, 32'd2, 32'd0, 32'd0), 1'b0, 32'd0, 1'b0};
    vecs[5] = '{mk(OP_LUI,   3'b000, 7'b0000000, 5'd9,  32'd0, 32'd0, 32'h1234_5000, 32'd0), 1'b1, 32'h1234_5000, 1'b0};
    vecs[6] = '{mk(OP_AUIPC, 3'b000, 7'b0000000, 5'd10, 32'd0, 32'd0, 32'h1000, 32'h2000), 1'b0, 32'h3000, 1'b0};
    vecs[7] = '{mk(OP_R,     3'b000, 7'b0000000, 5'd11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0), 1'b1, 32'd0, 1'b0};

    {b1.req_valid, b1.rsp_ready, b1.req0_data, b1.req1_data} = '0;
    {b3.req_valid, b3.rsp_ready, b3.req0_data, b3.req1_data} = '0;
    {bw.req_valid, bw.rsp_ready, bw.req0_data, bw.req1_data} = '0;

    do_reset();
    #1;
    check("rst_req_ready", b1.req_ready, 2'b00);
    check("rst_rsp_valid", b1.rsp_valid, 2'b00);
    check("rst_rsp_data", b1.rsp_data, '0);
    check("rst_alu_req_zero", (b1.alu_req === '0), 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_op_count", cnt1, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Contention straight after reset: grants must go 0,1,0,1.
    do_reset();
    b1.req0_data = mk(OP_R, 3'b000, 7'b0100000, 5'd1, 32'd10, 32'd20, 32'd0, 32'd0);
    b1.req1_data = mk(OP_I, 3'b000, 7'b0000000, 5'd2, 32'd10, 32'd0, 32'd15, 32'd0);
    b1.req_valid = 2'b11;
    #1 check("cont_grant0", b1.req_ready, 2'b01);
    @(negedge clk);
    b1.req0_data = mk(OP_R, 3'b000, 7'b0000000, 5'd3, 32'd3, 32'd4, 32'd0, 32'd0);
    #1 check("cont_exec_no_ready", b1.req_ready, 2'b00);
    @(negedge clk);
    check("cont_rsp0_valid", b1.rsp_valid, 2'b01);
    check("cont_rsp0_result", b1.rsp_data.result, 32'hFFFF_FFF6);
    check("cont_resp_no_ready", b1.req_ready, 2'b00);
    b1.rsp_ready = 2'b01;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    #1 check("cont_grant1", b1.req_ready, 2'b10);
    @(negedge clk);
    b1.req1_data = mk(OP_R, 3'b000, 7'b0000000, 5'd4, 32'd40, 32'd2, 32'd0, 32'd0);
    @(negedge clk);
    check("cont_rsp1_valid", b1.rsp_valid, 2'b10);
    check("cont_rsp1_result", b1.rsp_data.result, 32'd25);
    check("cont_rsp1_tag", b1.rsp_data.tag, 1'b1);
    b1.rsp_ready = 2'b10;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    #1 check("cont_grant2", b1.req_ready, 2'b01);
    @(negedge clk);
    b1.req_valid = 2'b10;
    @(negedge clk);
    check("cont_rsp2_result", b1.rsp_data.result, 32'd7);
    b1.rsp_ready = 2'b01;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    #1 check("cont_grant3", b1.req_ready, 2'b10);
    @(negedge clk);
    b1.req_valid = 2'b00;
    @(negedge clk);
    check("cont_rsp3_result", b1.rsp_data.result, 32'd42);
    b1.rsp_ready = 2'b10;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    exp_cnt = 4;
    check("cont_op_count", cnt1, 32'd4);

    // Backpressure on port 1 while port 0 is waiting and drives the wrong rsp_ready.
    b1.req1_data = mk(OP_B, 3'b000, 7'b0000000, 5'd0, 32'd30, 32'd30, 32'd0, 32'd0);
    b1.req_valid = 2'b10;
    #1 check("bp_accept", b1.req_ready, 2'b10);
    @(negedge clk);
    b1.req0_data = mk(OP_R, 3'b000, 7'b0000000, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
    b1.req_valid = 2'b01;
    @(negedge clk);
    b1.rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_rsp_valid_%0d", k), b1.rsp_valid, 2'b10);
      check($sformatf("bp_branch_%0d", k), b1.rsp_data.branch_taken, 1'b1);
      check($sformatf("bp_result_%0d", k), b1.rsp_data.result, 32'd0);
      check($sformatf("bp_req_ready_%0d", k), b1.req_ready, 2'b00);
      @(negedge clk);
    end
    b1.req_valid = 2'b00;
    b1.rsp_ready = 2'b10;
    @(negedge clk);
    b1.rsp_ready = 2'b00;
    exp_cnt++;
    check("bp_done_valid", b1.rsp_valid, 2'b00);
    check("bp_done_count", cnt1, exp_cnt);

    // Reset during EXEC after a port 0 grant: op dropped, next tie back to port 0.
    b1.req0_data = mk(OP_R, 3'b000, 7'b0000000, 5'd1, 32'd1, 32'd1, 32'd0, 32'd0);
    b1.req_valid = 2'b01;
    #1 check("rme_accept", b1.req_ready, 2'b01);
    @(negedge clk);
    b1.req_valid = 2'b00;
    check("rme_in_exec", busy1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    check("rme_rsp_valid", b1.rsp_valid, 2'b00);
    check("rme_busy", busy1, 1'b0);
    check("rme_alu_req_zero", (b1.alu_req === '0), 1'b1);
    check("rme_rsp_data", b1.rsp_data, '0);
    check("rme_op_count", cnt1, 32'd0);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (b1.rsp_valid != 2'b00) n++;
    end
    check("rme_no_late_rsp", n, 0);
    b1.req0_data = mk(OP_R, 3'b000, 7'b0000000, 5'd7, 32'd2, 32'd2, 32'd0, 32'd0);
    b1.req1_data = mk(OP_R, 3'b000, 7'b0000000, 5'd8, 32'd5, 32'd5, 32'd0, 32'd0);
    b1.req_valid = 2'b11;
    #1 check("rme_next_grant", b1.req_ready, 2'b01);
    @(negedge clk);
    b1.req_valid = 2'b00;
    @(negedge clk);
    check("rme_rsp_result", b1.rsp_data.result, 32'd4);
    b1.rsp_ready = 2'b01;
    @(negedge clk);
    b1.rsp_ready = 2'b00;

    // Settle time with EXEC_CYCLES=3.
    op3 = mk(OP_AUIPC, 3'b000, 7'b0000000, 5'd12, 32'd0, 32'd0, 32'h1000, 32'h2000);
    b3.req0_data = op3;
    b3.req_valid = 2'b01;
    #1 check("s3_accept", b3.req_ready, 2'b01);
    @(negedge clk);
    b3.req_valid = 2'b00;
    b3.req0_data = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("s3_alu_req_%0d", k), (b3.alu_req === op3), 1'b1);
      check($sformatf("s3_no_rsp_%0d", k), b3.rsp_valid, 2'b00);
      @(negedge clk);
    end
    check("s3_rsp_valid", b3.rsp_valid, 2'b01);
    check("s3_result", b3.rsp_data.result, 32'h3000);
    check("s3_alu_req_idle", (b3.alu_req === '0), 1'b1);
    b3.rsp_ready = 2'b01;
    @(negedge clk);
    b3.rsp_ready = 2'b00;
    check("s3_op_count", cnt3, 32'd1);

    // 16 back-to-back ops on the 4-bit counter, both ports always requesting.
    bw.req0_data = mk(OP_R, 3'b000, 7'b0000000, 5'd1, 32'd1, 32'd2, 32'd0, 32'd0);
    bw.req1_data = mk(OP_R, 3'b000, 7'b0000000, 5'd2, 32'd3, 32'd4, 32'd0, 32'd0);
    bw.rsp_ready = 2'b11;
    bw.req_valid = 2'b11;
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (bw.rsp_valid == 2'b00 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) begin
        check("wrap_rsp_timeout", n, 0);
        break;
      end
      check($sformatf("wrap_owner_%0d", i), bw.rsp_valid, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
      if (i == 14) check("wrap_count_15", cntw, 4'd15);
      if (i == 15) begin
        bw.req_valid = 2'b00;
        check("wrap_count_0", cntw, 4'd0);
      end
    end
    bw.rsp_ready = 2'b00;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
